// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the memory stage and dmem_ctrl.
// master drives requests; slave returns read word, offset, stall, fault, busy.
interface dmem_if #(
    parameter int N = 64
);
    logic         memRead_E;
    logic         memWrite_E;
    logic [N-1:0] address_E;
    logic [N-1:0] writeData_E;
    logic [2:0]   memWidth;
    logic [N-1:0] DM_readData_E;
    logic [2:0]   byteOffset;
    logic         stall;
    logic         misaligned_fault;
    logic         busy;

    modport master (
        output memRead_E, memWrite_E, address_E, writeData_E, memWidth,
        input  DM_readData_E, byteOffset, stall, misaligned_fault, busy
    );

    modport slave (
        input  memRead_E, memWrite_E, address_E, writeData_E, memWidth,
        output DM_readData_E, byteOffset, stall, misaligned_fault, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM, byte-lane stores, wait states, faults.
// Ports: clk, reset (sync, active-low), bus (dmem_if.slave).
module dmem_ctrl #(
    parameter int N     = 64,
    parameter int DEPTH = 512,
    parameter int WAIT  = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic [AW+2:0] addr_q;
    logic [N-1:0]  data_q;
    logic [1:0]    wid_q;
    logic          wr_q;
    logic          rd_q;

    logic [N-1:0] mem [DEPTH];

    logic [N-1:0] rdata_q;
    logic [2:0]   off_q;
    logic         fault_q;

    logic         req;
    logic         aligned;
    logic         open_st;
    logic         accept;
    logic         reject;
    logic         fire;
    logic [2:0]   low_mask;
    logic [7:0]   lanes;
    logic [7:0]   strobe;
    logic [N-1:0] wdata;
    logic [AW-1:0] idx;
    logic [2:0]   off;
    logic         unused_addr;

    // Upper address bits only alias; they never select a word.
    assign unused_addr = ^bus.address_E[N-1:AW+3];

    always_comb begin
        low_mask = 3'b000;
        unique case (bus.memWidth[1:0])
            2'd0: low_mask = 3'b000;
            2'd1: low_mask = 3'b001;
            2'd2: low_mask = 3'b011;
            2'd3: low_mask = 3'b111;
            default: low_mask = 3'b000;
        endcase
    end

    assign req     = bus.memRead_E | bus.memWrite_E;
    assign aligned = ~bus.memWidth[2] &&
                     ((bus.address_E[2:0] & low_mask) == 3'b000);
    assign open_st = (state == IDLE) || (state == DONE);
    assign accept  = open_st & req & aligned;
    assign reject  = open_st & req & ~aligned;
    assign fire    = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n = BUSY;
                    cnt_n   = 4'(WAIT);
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) state_n = DONE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= '0;
            off_q   <= 3'd0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            fault_q <= reject;
            // Stores win over loads, so only a pure load refreshes the word.
            if (fire && rd_q && !wr_q) begin
                rdata_q <= mem[idx];
                off_q   <= off;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus.address_E[AW+2:0];
            data_q <= bus.writeData_E;
            wid_q  <= bus.memWidth[1:0];
            wr_q   <= bus.memWrite_E;
            rd_q   <= bus.memRead_E;
        end
    end

    always_comb begin
        lanes = 8'h00;
        unique case (wid_q)
            2'd0: lanes = 8'h01;
            2'd1: lanes = 8'h03;
            2'd2: lanes = 8'h0F;
            2'd3: lanes = 8'hFF;
            default: lanes = 8'h00;
        endcase
    end

    assign idx    = addr_q[AW+2:3];
    assign off    = addr_q[2:0];
    assign strobe = lanes << off;
    assign wdata  = data_q << {off, 3'b000};

    // A reset arriving during the access suppresses the commit.
    always_ff @(posedge clk) begin
        if (reset && fire && wr_q) begin
            for (int b = 0; b < 8; b++) begin
                if (strobe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign bus.stall            = accept | (state == BUSY);
    assign bus.busy             = (state == BUSY);
    assign bus.DM_readData_E    = rdata_q;
    assign bus.byteOffset       = off_q;
    assign bus.misaligned_fault = fault_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: WAIT=2 and WAIT=0 instances against a byte-array model.
// Directed steps from the test plan, then randomized accesses.
module tb_dmem_ctrl;
    localparam int N     = 64;
    localparam int DEPTH = 512;
    localparam int NB    = DEPTH * 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_if #(.N(N)) b2 ();
    dmem_if #(.N(N)) b0 ();

    dmem_ctrl #(.N(N), .DEPTH(DEPTH), .WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );
    dmem_ctrl #(.N(N), .DEPTH(DEPTH), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  mm [NB];
    logic [63:0] exp_rd;
    logic [2:0]  exp_off;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] w,
                         input logic [63:0] a, input logic [63:0] d);
        b2.memRead_E = rd; b2.memWrite_E = wr; b2.memWidth = w;
        b2.address_E = a;  b2.writeData_E = d;
        b0.memRead_E = rd; b0.memWrite_E = wr; b0.memWidth = w;
        b0.address_E = a;  b0.writeData_E = d;
    endtask

    function automatic logic is_ok(input logic [2:0] w, input logic [63:0] a);
        return !w[2] && ((a % (64'd1 << w[1:0])) == 64'd0);
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] r;
        int base;
        base = int'((a % NB) / 8) * 8;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mm[base + i];
        return r;
    endfunction

    task automatic model_store(input logic [2:0] w, input logic [63:0] a,
                               input logic [63:0] d);
        int base;
        base = int'(a % NB);
        for (int i = 0; i < (1 << w[1:0]); i++) mm[base + i] = d[8*i +: 8];
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] w,
                          input logic [63:0] a, input logic [63:0] d);
        logic g;
        int n2, n0;
        g = is_ok(w, a);
        @(negedge clk);
        drive(rd, wr, w, a, d);
        #1;
        chk("req_stall2", b2.stall, g);
        chk("req_stall0", b0.stall, g);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        chk("fault2", b2.misaligned_fault, !g);
        chk("fault0", b0.misaligned_fault, !g);
        if (g) begin
            n2 = 0;
            n0 = 0;
            for (int k = 0; k < 40 && (b2.stall || b0.stall); k++) begin
                if (b2.stall) n2++;
                if (b0.stall) n0++;
                @(posedge clk);
                #1;
            end
            chk("stall_len2", n2, 3);
            chk("stall_len0", n0, 1);
            if (wr) begin
                model_store(w, a, d);
            end else begin
                exp_rd  = word_at(a);
                exp_off = a[2:0];
            end
        end else begin
            @(posedge clk);
            #1;
            chk("fault_once2", b2.misaligned_fault, 1'b0);
            chk("fault_once0", b0.misaligned_fault, 1'b0);
            chk("fault_nostall2", b2.stall, 1'b0);
            chk("fault_nostall0", b0.stall, 1'b0);
        end
        chk("rdata2", b2.DM_readData_E, exp_rd);
        chk("rdata0", b0.DM_readData_E, exp_rd);
        chk("off2", b2.byteOffset, exp_off);
        chk("off0", b0.byteOffset, exp_off);
        chk("idle2", b2.busy, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] a;
        logic [2:0]  w;
        int sel;

        exp_rd  = 64'd0;
        exp_off = 3'd0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdata2", b2.DM_readData_E, 64'd0);
        chk("rst_rdata0", b0.DM_readData_E, 64'd0);
        chk("rst_off2", b2.byteOffset, 3'd0);
        chk("rst_off0", b0.byteOffset, 3'd0);
        chk("rst_stall2", b2.stall, 1'b0);
        chk("rst_stall0", b0.stall, 1'b0);
        chk("rst_busy2", b2.busy, 1'b0);
        chk("rst_fault2", b2.misaligned_fault, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            access(1'b0, 1'b1, 3'd3, 64'(i * 8), d);
        end

        access(1'b0, 1'b1, 3'd3, 64'h10, 64'h1122334455667788);
        access(1'b1, 1'b0, 3'd3, 64'h10, 64'd0);
        chk("sd_ld", b2.DM_readData_E, 64'h1122334455667788);

        access(1'b0, 1'b1, 3'd0, 64'h13, 64'hAB);
        access(1'b1, 1'b0, 3'd3, 64'h10, 64'd0);
        chk("sb_ld", b2.DM_readData_E, 64'h11223344AB667788);

        access(1'b1, 1'b0, 3'd1, 64'h16, 64'd0);
        chk("lh_off", b2.byteOffset, 3'd6);
        chk("lh_word", b2.DM_readData_E, 64'h11223344AB667788);
        access(1'b1, 1'b0, 3'd2, 64'h14, 64'd0);
        chk("lw_off", b2.byteOffset, 3'd4);

        access(1'b0, 1'b1, 3'd2, 64'h12, 64'hFFFF_FFFF);
        access(1'b1, 1'b0, 3'd3, 64'h10, 64'd0);
        chk("sw_mis_nochg", b2.DM_readData_E, 64'h11223344AB667788);
        access(1'b1, 1'b0, 3'b100, 64'h10, 64'd0);

        access(1'b1, 1'b0, 3'd3, 64'h1010, 64'd0);
        chk("alias_ld", b2.DM_readData_E, 64'h11223344AB667788);
        access(1'b0, 1'b1, 3'd3, 64'h1018, 64'hCAFE_F00D_1234_5678);
        access(1'b1, 1'b0, 3'd3, 64'h18, 64'd0);
        chk("alias_sd", b2.DM_readData_E, 64'hCAFE_F00D_1234_5678);

        // Back-to-back loads on the WAIT=0 instance only.
        @(negedge clk);
        b0.memRead_E = 1'b1;
        b0.memWidth  = 3'd3;
        b0.address_E = 64'h10;
        @(posedge clk);
        #1;
        chk("b2b_busy_a", b0.busy, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_done_a", b0.busy, 1'b0);
        chk("b2b_rdata_a", b0.DM_readData_E, word_at(64'h10));
        b0.address_E = 64'h18;
        #1;
        chk("b2b_stall_done", b0.stall, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_busy_b", b0.busy, 1'b1);
        b0.memRead_E = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_done_b", b0.busy, 1'b0);
        chk("b2b_stall_b", b0.stall, 1'b0);
        chk("b2b_rdata_b", b0.DM_readData_E, word_at(64'h18));

        // Reset during the BUSY phase of a store.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd3, 64'h20, 64'hDEAD_BEEF_0BAD_F00D);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        chk("rmid_busy2", b2.busy, 1'b1);
        chk("rmid_busy0", b0.busy, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rmid_idle2", b2.busy, 1'b0);
        chk("rmid_idle0", b0.busy, 1'b0);
        chk("rmid_rdata2", b2.DM_readData_E, 64'd0);
        chk("rmid_rdata0", b0.DM_readData_E, 64'd0);
        exp_rd  = 64'd0;
        exp_off = 3'd0;
        access(1'b1, 1'b0, 3'd3, 64'h20, 64'd0);
        chk("rmid_nocommit", (b2.DM_readData_E == 64'hDEAD_BEEF_0BAD_F00D),
            1'b0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 2);
            w   = 3'($urandom_range(0, 5));
            a   = 64'($urandom_range(0, 63)) +
                  64'(4096 * $urandom_range(0, 3));
            d   = {$urandom, $urandom};
            access(sel != 1, sel != 0, w, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
